btn_event_reader: RTL and testbench
===================================

// Module: btn_event_reader
// PURPOSE
//  Input-side peripheral for nnRvSoc. Samples the raw push-buttons (BTNL/BTNR/BTNU/BTND), then synchronises and
//  debounces them. Each debounced press or release becomes an event word in a show-ahead FIFO that the CPU
//  drains through a read strobe. It complements the SoC's output path (LED, VGA coordinates) with a
//  loss-aware input path.
// PARAMETERS
//  N_BTN            4       number of buttons; bit i of btn_in = button index i
//  DEBOUNCE_CYCLES  50000   consecutive stable CLK cycles needed to accept a level change (>=2)
//  FIFO_DEPTH       8       event FIFO entries; power of two, >=2
//  (localparam IDX_W = clog2(N_BTN) (min 1); EVT_W = IDX_W+1; CNT_W = clog2(FIFO_DEPTH)+1)
// PORTS
//  CLK        in   1          system clock (SoC CLK domain)
//  RST_N      in   1          synchronous reset, active-low
//  btn_in     in   N_BTN      raw asynchronous button levels, 1 = pressed
//  btn_state  out  N_BTN      debounced levels
//  evt_valid  out  1          FIFO non-empty; evt_data is valid
//  evt_data   out  EVT_W      head event {kind, idx}; kind 1 = press, 0 = release
//  evt_rd     in   1          pop head; honoured only when evt_valid
//  evt_count  out  CNT_W      number of entries in the FIFO (0..FIFO_DEPTH)
//  ovf        out  1          sticky: at least one event was lost
//  ovf_clr    in   1          clears ovf
// BEHAVIOUR
//  Reset (RST_N=0 at a CLK edge): sync flops, debounce counters, btn_state, pending bits, FIFO pointers
//   and ovf all go to 0. evt_valid=0, evt_count=0, evt_data=0. Reset mid-debounce discards the partial count.
//   A button still held after reset produces a normal press event once debounced.
//  Sync: btn_in passes through a 2-flop synchroniser per bit, giving s[i].
//  Debounce, per button: if s[i]==btn_state[i], cnt<=0. Otherwise cnt<=cnt+1.
//   When s[i]!=btn_state[i] and cnt==DEBOUNCE_CYCLES-1: btn_state[i]<=s[i], cnt<=0, and a flip is signalled.
//   Any glitch shorter than DEBOUNCE_CYCLES restarts the count and produces no event.
//   Latency: btn_in change to btn_state change = DEBOUNCE_CYCLES+2 CLK cycles.
//  Pending: a flip sets pend[i]=1 and pkind[i]=new level.
//   If pend[i] is already 1 at a flip, the older event is overwritten, ovf<=1, and pkind[i] takes the new level.
//  Arbiter: each cycle, if any pend is set and the FIFO can accept an entry, push {pkind[j], j} for the
//   lowest j with pend[j] set, and clear pend[j]. At most one push per cycle.
//   Simultaneous flips on several buttons therefore drain in ascending index order, one per cycle.
//   A flip and a clear of the same pend bit in the same cycle: the flip wins, and the bit stays set with the new kind.
//  FIFO: show-ahead; evt_data = entry at head, and reads 0 when empty.
//   "Can accept" = (evt_count<FIFO_DEPTH) || (evt_rd && evt_valid).
//   When full with a pop in the same cycle, the push happens and evt_count is unchanged.
//   evt_rd while empty is ignored.
//   When full with no pop, pending events wait in pend; they are lost only via the overwrite rule above.
//   Pointers wrap modulo FIFO_DEPTH. evt_count is updated in the same cycle as the push/pop (registered).
//  ovf: set by an overwrite; cleared by ovf_clr. If set and clear happen in the same cycle, set wins.
//  All outputs are registered except evt_valid and evt_data, which are decoded from registered count and head.
// STRUCTURE
//  Package nn_io_pkg holds:
//   - EVT_PRESS=1'b1 and EVT_RELEASE=1'b0
//   - the default N_BTN=4
//   - typedef btn_evt_t {logic kind; logic [IDX_W-1:0] idx;}
//   - button index constants BTN_L=0, BTN_R=1, BTN_U=2, BTN_D=3, matching the SoC input ordering
//  Sub-module btn_debounce: the 2-flop synchroniser, counter and stable level for one button.
//   It outputs level and flip; it is instantiated N_BTN times via generate.
//  The pend/arbiter logic and the FIFO stay inline (no separate FIFO module).
// TESTING  (sim with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, N_BTN=4)
//  1 Reset, then btn_in=4'b0001 held. btn_state[0]=1 exactly 6 cycles after the change, and one cycle
//    later evt_valid=1, evt_data=3'b1_00, evt_count=1. Pulse evt_rd: evt_valid=0, evt_count=0.
//  2 Glitch: btn_in[1] high for 3 cycles, then low. Response: no btn_state change, evt_count stays 0.
//  3 Simultaneous: btn_in 0000->1111 in one cycle. Four events on four consecutive cycles:
//    {1,0},{1,1},{1,2},{1,3}; evt_count reaches 4, FIFO full.
//  4 Full + pending: with the FIFO full from test 3, release button 2 (flip -> pend[2]).
//    Press it again after the debounce time, without reading: ovf=1, pend holds {1,2}.
//    Read one entry: {1,2} is pushed in the same cycle as the pop, and evt_count stays 4.
//  5 ovf_clr and an overwrite in the same cycle -> ovf stays 1. ovf_clr alone -> ovf=0 next cycle.
//  6 Drive RST_N=0 for 1 cycle mid-debounce with events queued. Response: evt_count=0, btn_state=0, ovf=0.
//    The held buttons re-emit press events after DEBOUNCE_CYCLES+2 cycles.

Source files
------------

// File: rtl/nn_io_pkg.sv
// rtl/nn_io_pkg.sv - shared constants and types for the nnRvSoc button input path
//
// Purpose: event kind encodings, default button count, event word layout and
//          the button index assignment used by the SoC input ordering.
// Ports:   none (package).
package nn_io_pkg;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  localparam int N_BTN_DEFAULT = 4;

  // Index width for n buttons; a single button still needs one index bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEFAULT = idx_width(N_BTN_DEFAULT);

  typedef struct packed {
    logic                     kind;
    logic [IDX_W_DEFAULT-1:0] idx;
  } btn_evt_t;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_U = 2;
  localparam int BTN_D = 3;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser and debounce counter for one button
//
// Purpose: synchronises one raw button level and accepts a level change only
//          after it has been stable for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous reset, active-low
//   btn_raw  in   raw asynchronous button level
//   level    out  debounced (registered) level
//   flip     out  high in the cycle the debounced level is about to change
module btn_debounce #(
  parameter  int DEBOUNCE_CYCLES = 50000,
  localparam int CW              = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic flip
);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          differs;

  assign differs = (sync2 != level);
  // Combinational so the pending bit is set on the same edge that updates level.
  assign flip    = differs && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (!differs) begin
        cnt <= '0;
      end else if (flip) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/btn_event_reader.sv
// rtl/btn_event_reader.sv - debounced push-button event queue with overflow flag
//
// Purpose: debounces N_BTN buttons, turns each accepted press/release into a
//          {kind, idx} event, and queues events in a show-ahead FIFO drained by
//          the CPU.
// Ports:
//   CLK        in   system clock
//   RST_N      in   synchronous reset, active-low
//   btn_in     in   raw button levels, 1 = pressed
//   btn_state  out  debounced levels
//   evt_valid  out  FIFO non-empty
//   evt_data   out  head event {kind, idx}, 0 when empty
//   evt_rd     in   pop head (ignored when empty)
//   evt_count  out  FIFO occupancy
//   ovf        out  sticky event-lost flag
//   ovf_clr    in   clears ovf
module btn_event_reader
  import nn_io_pkg::*;
#(
  parameter  int N_BTN           = N_BTN_DEFAULT,
  parameter  int DEBOUNCE_CYCLES = 50000,
  parameter  int FIFO_DEPTH      = 8,
  localparam int IDX_W           = idx_width(N_BTN),
  localparam int EVT_W           = IDX_W + 1,
  localparam int CNT_W           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_state,
  output logic             evt_valid,
  output logic [EVT_W-1:0] evt_data,
  input  logic             evt_rd,
  output logic [CNT_W-1:0] evt_count,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [N_BTN-1:0] flip;
  logic [N_BTN-1:0] pend;
  logic [N_BTN-1:0] pkind;
  logic [N_BTN-1:0] clr_mask;
  logic [N_BTN-1:0] overwrite;
  logic [IDX_W-1:0] sel;
  logic             any_pend;
  logic             pop;
  logic             push;
  logic             can_accept;

  logic [EVT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  for (genvar i = 0; i < N_BTN; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (CLK),
      .rst_n   (RST_N),
      .btn_raw (btn_in[i]),
      .level   (btn_state[i]),
      .flip    (flip[i])
    );
  end

  // Lowest-index pending button wins; scanning downward leaves the lowest set.
  always_comb begin
    sel = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend[i]) sel = IDX_W'(i);
    end
  end

  assign any_pend   = |pend;
  assign pop        = evt_rd && evt_valid;
  assign can_accept = (evt_count < CNT_W'(FIFO_DEPTH)) || pop;
  assign push       = any_pend && can_accept;

  always_comb begin
    clr_mask = '0;
    if (push) clr_mask[sel] = 1'b1;
  end

  // An older pending event is only lost if it is not leaving for the FIFO
  // on this very edge.
  assign overwrite = flip & pend & ~clr_mask;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pend  <= '0;
      pkind <= '0;
      ovf   <= 1'b0;
    end else begin
      // A flip overrides a clear on the same bit, keeping the newer event.
      pend  <= (pend & ~clr_mask) | flip;
      // The new debounced level is the complement of the current one.
      pkind <= (pkind & ~flip) | (~btn_state & flip);
      if (|overwrite) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {pkind[sel], sel};
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   evt_count <= evt_count + CNT_W'(1);
        2'b01:   evt_count <= evt_count - CNT_W'(1);
        default: evt_count <= evt_count;
      endcase
    end
  end

  assign evt_valid = (evt_count != '0);
  assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_btn_event_reader.sv
// tb/tb_btn_event_reader.sv - self-checking bench for btn_event_reader
module tb_btn_event_reader;

  localparam int N     = 4;
  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_in;
  logic [3:0] btn_state;
  logic       evt_valid;
  logic [2:0] evt_data;
  logic       evt_rd;
  logic [2:0] evt_count;
  logic       ovf;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;

  logic [2:0] sb[$];

  typedef struct {
    logic [3:0] btn;
    logic [3:0] state;
    logic [2:0] count;
  } vec_t;

  vec_t tbl[10];

  btn_event_reader #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .btn_in    (btn_in),
    .btn_state (btn_state),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .evt_rd    (evt_rd),
    .evt_count (evt_count),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_check(input string name);
    logic [2:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %0h expected none", name, evt_data);
    end else begin
      exp = sb.pop_front();
      chk({name, "_valid"}, 32'(evt_valid), 32'd1);
      chk({name, "_data"}, 32'(evt_data), 32'(exp));
    end
    evt_rd = 1'b1;
    cyc(1);
    evt_rd = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      tbl[i].btn   = 4'b1111;
      tbl[i].state = (i < 5) ? 4'b0000 : 4'b1111;
      tbl[i].count = (i < 6) ? 3'd0 : 3'(i - 5);
    end

    rst_n   = 1'b0;
    btn_in  = 4'b0000;
    evt_rd  = 1'b0;
    ovf_clr = 1'b0;
    cyc(2);
    chk("rst_state", 32'(btn_state), 32'd0);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_count", 32'(evt_count), 32'd0);
    chk("rst_data",  32'(evt_data),  32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);
    rst_n = 1'b1;

    // Single press on button 0
    btn_in = 4'b0001;
    sb.push_back(3'b100);
    cyc(5);
    chk("t1_state_early", 32'(btn_state), 32'd0);
    cyc(1);
    chk("t1_state", 32'(btn_state), 32'b0001);
    chk("t1_count_pre", 32'(evt_count), 32'd0);
    cyc(1);
    chk("t1_count", 32'(evt_count), 32'd1);
    pop_check("t1_pop");
    chk("t1_valid_after", 32'(evt_valid), 32'd0);
    chk("t1_count_after", 32'(evt_count), 32'd0);
    evt_rd = 1'b1;
    cyc(1);
    evt_rd = 1'b0;
    chk("t1_rd_empty_count", 32'(evt_count), 32'd0);
    chk("t1_rd_empty_valid", 32'(evt_valid), 32'd0);

    // Glitch on button 1 shorter than the debounce window
    btn_in = 4'b0011;
    cyc(3);
    btn_in = 4'b0001;
    cyc(12);
    chk("t2_state", 32'(btn_state), 32'b0001);
    chk("t2_count", 32'(evt_count), 32'd0);

    // Release button 0 so all buttons start from 0
    btn_in = 4'b0000;
    sb.push_back(3'b000);
    cyc(7);
    pop_check("t3_rel");

    // Simultaneous press of all buttons, table-driven per-cycle expectations
    sb.push_back(3'b100);
    sb.push_back(3'b101);
    sb.push_back(3'b110);
    sb.push_back(3'b111);
    for (int i = 0; i < 10; i++) begin
      btn_in = tbl[i].btn;
      cyc(1);
      chk($sformatf("t3_state_c%0d", i + 1), 32'(btn_state), 32'(tbl[i].state));
      chk($sformatf("t3_count_c%0d", i + 1), 32'(evt_count), 32'(tbl[i].count));
    end
    chk("t3_head", 32'(evt_data), 32'b100);

    // Full FIFO: release then re-press button 2 without reading
    btn_in = 4'b1011;
    cyc(7);
    chk("t4_state_rel", 32'(btn_state), 32'b1011);
    chk("t4_count_full", 32'(evt_count), 32'd4);
    chk("t4_ovf_pre", 32'(ovf), 32'd0);
    btn_in = 4'b1111;
    cyc(6);
    chk("t4_state_press", 32'(btn_state), 32'b1111);
    chk("t4_ovf_set", 32'(ovf), 32'd1);
    chk("t4_count_hold", 32'(evt_count), 32'd4);
    sb.push_back(3'b110);
    pop_check("t4_pop");
    chk("t4_count_after", 32'(evt_count), 32'd4);

    // ovf_clr alone, then clear coinciding with an overwrite
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("t5_clr", 32'(ovf), 32'd0);
    btn_in = 4'b0111;
    cyc(7);
    chk("t5_state_rel", 32'(btn_state), 32'b0111);
    chk("t5_ovf_pre", 32'(ovf), 32'd0);
    btn_in = 4'b1111;
    cyc(5);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("t5_set_wins", 32'(ovf), 32'd1);
    chk("t5_state_press", 32'(btn_state), 32'b1111);
    sb.push_back(3'b111);
    pop_check("t5_pop1");
    pop_check("t5_pop2");
    chk("t5_count", 32'(evt_count), 32'd3);

    // Reset mid-debounce with events queued and ovf set
    btn_in = 4'b0011;
    cyc(3);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("t6_count", 32'(evt_count), 32'd0);
    chk("t6_state", 32'(btn_state), 32'd0);
    chk("t6_ovf",   32'(ovf),       32'd0);
    chk("t6_valid", 32'(evt_valid), 32'd0);
    sb.delete();
    sb.push_back(3'b100);
    sb.push_back(3'b101);
    cyc(5);
    chk("t6_state_early", 32'(btn_state), 32'd0);
    cyc(1);
    chk("t6_state_re", 32'(btn_state), 32'b0011);
    cyc(2);
    chk("t6_count_re", 32'(evt_count), 32'd2);
    pop_check("t6_pop0");
    pop_check("t6_pop1");
    chk("t6_count_end", 32'(evt_count), 32'd0);
    chk("t6_valid_end", 32'(evt_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
